// File: rtl/ram_master.sv
// Request/response master driving a single-port RAM with 1-cycle read latency.
// Optional zero-fill of the RAM is built when RAM_MASTER_CLEAR_EN is defined.
module ram_master #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int MEMORY_DEPTH  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]    req_data_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_WIDTH-1:0]    rsp_data_o,
  output logic [ADDRESS_WIDTH-1:0] ram_address_o,
  output logic [DATA_WIDTH-1:0]    ram_data_o,
  output logic                     ram_we_o,
  input  logic [DATA_WIDTH-1:0]    ram_data_i,
  input  logic                     clear_i,
  output logic                     busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_CAPTURE,
    RESP,
    CLEAR
  } state_t;

  state_t                   state;
  state_t                   state_n;
  logic [ADDRESS_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0]    wdata_n;
  logic                     we_n;
  logic                     rvalid_n;
  logic [DATA_WIDTH-1:0]    rdata_n;

`ifdef RAM_MASTER_CLEAR_EN
  localparam logic [ADDRESS_WIDTH-1:0] LAST =
    ADDRESS_WIDTH'(MEMORY_DEPTH - 1);
`else
  localparam int unused_depth = MEMORY_DEPTH;
  logic unused_clear;
  assign unused_clear = clear_i;
`endif

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      ram_address_o <= '0;
      ram_data_o    <= '0;
      ram_we_o      <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= '0;
    end else begin
      state         <= state_n;
      ram_address_o <= addr_n;
      ram_data_o    <= wdata_n;
      ram_we_o      <= we_n;
      rsp_valid_o   <= rvalid_n;
      rsp_data_o    <= rdata_n;
    end
  end

  // ram_we_o defaults low so only WRITE/CLEAR entry can raise it
  always_comb begin
    state_n  = state;
    addr_n   = ram_address_o;
    wdata_n  = ram_data_o;
    we_n     = 1'b0;
    rvalid_n = rsp_valid_o;
    rdata_n  = rsp_data_o;
    unique case (state)
      IDLE: begin
`ifdef RAM_MASTER_CLEAR_EN
        if (clear_i) begin
          addr_n  = '0;
          wdata_n = '0;
          we_n    = 1'b1;
          state_n = CLEAR;
        end else
`endif
        if (req_valid_i) begin
          addr_n = req_addr_i;
          if (req_we_i) begin
            wdata_n = req_data_i;
            we_n    = 1'b1;
            state_n = WRITE;
          end else begin
            state_n = RD_ISSUE;
          end
        end
      end
      WRITE:    state_n = IDLE;
      RD_ISSUE: state_n = RD_CAPTURE;
      RD_CAPTURE: begin
        rdata_n  = ram_data_i;
        rvalid_n = 1'b1;
        state_n  = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rvalid_n = 1'b0;
          state_n  = IDLE;
        end
      end
      CLEAR: begin
`ifdef RAM_MASTER_CLEAR_EN
        if (ram_address_o == LAST) begin
          state_n = IDLE;
        end else begin
          addr_n = ram_address_o + ADDRESS_WIDTH'(1);
          we_n   = 1'b1;
        end
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: behavioural RAM, golden memory array,
// table vectors, back-to-back, reset-in-response, random and clear tests.
module tb_ram_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  ram_address;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        clear;
  logic        busy;

  int checks;
  int errors;

  logic [31:0] mem [32];
  logic [31:0] gm  [32];

  ram_master dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_addr_i    (req_addr),
    .req_data_i    (req_data),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_data_o    (rsp_data),
    .ram_address_o (ram_address),
    .ram_data_o    (ram_wdata),
    .ram_we_o      (ram_we),
    .ram_data_i    (ram_rdata),
    .clear_i       (clear),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, registered read output
  always @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_wdata;
    ram_rdata <= mem[ram_address];
  end

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    int          stall;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_write(logic [4:0] a, logic [31:0] d);
    check("wr_ready", req_ready, 1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_data  = d;
    step();
    req_valid = 1'b0;
    check("wr_we", ram_we, 1);
    check("wr_addr", ram_address, a);
    check("wr_data", ram_wdata, d);
    check("wr_busy", {busy, req_ready}, 2'b10);
    step();
    check("wr_we_low", ram_we, 0);
    check("wr_idle", req_ready, 1);
    gm[a] = d;
  endtask

  task automatic do_read(logic [4:0] a, logic [31:0] e, int stall);
    check("rd_ready", req_ready, 1);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    check("rd_we", ram_we, 0);
    check("rd_addr", ram_address, a);
    check("rd_early1", rsp_valid, 0);
    step();
    check("rd_early2", rsp_valid, 0);
    step();
    check("rd_valid", rsp_valid, 1);
    check("rd_data", rsp_data, e);
    for (int s = 0; s < stall; s++) begin
      step();
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, e);
      check("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("hs_valid", rsp_valid, 0);
    check("hs_idle", req_ready, 1);
    check("hs_hold", rsp_data, e);
  endtask

  initial begin
    logic exp_ready;
    int   k;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    clear     = 1'b0;
    for (int i = 0; i < 32; i++) gm[i] = '0;

    vecs[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 32'h0,        0};
    vecs[1] = '{1'b0, 5'd3,  32'h0,        32'hDEADBEEF, 0};
    vecs[2] = '{1'b1, 5'd0,  32'h00000001, 32'h0,        0};
    vecs[3] = '{1'b1, 5'd31, 32'h80000000, 32'h0,        0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        32'h00000001, 5};
    vecs[5] = '{1'b0, 5'd31, 32'h0,        32'h80000000, 1};
    vecs[6] = '{1'b1, 5'd3,  32'h12345678, 32'h0,        0};
    vecs[7] = '{1'b0, 5'd3,  32'h0,        32'h12345678, 2};

    step();
    step();
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp", {rsp_valid, rsp_data}, 0);
    check("rst_ram", {ram_we, ram_address, ram_wdata}, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].we) do_write(vecs[i].addr, vecs[i].data);
      else do_read(vecs[i].addr, vecs[i].exp, vecs[i].stall);
    end

    // Back-to-back writes with req_valid held high
    exp_ready = 1'b1;
    k = 0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 5'd0;
    req_data  = 32'd0;
    for (int c = 0; c < 64; c++) begin
      step();
      if (exp_ready) begin
        gm[k] = 32'(k * 3);
        k++;
        req_addr = 5'(k);
        req_data = 32'(k * 3);
      end
      exp_ready = !exp_ready;
      check("b2b_ready", req_ready, exp_ready);
      if (k == 32) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    for (int a = 0; a < 32; a++) do_read(5'(a), 32'(a * 3), 0);

    // Reset while a response is pending
    do_write(5'd5, 32'hA5A5_0005);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 5'd5;
    step();
    req_valid = 1'b0;
    step();
    step();
    check("rr_valid", rsp_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rr_rsp", {rsp_valid, rsp_data}, 0);
    check("rr_ready", {req_ready, busy}, 2'b10);
    check("rr_ram", {ram_we, ram_address, ram_wdata}, 0);
    step();
    check("rr_quiet", rsp_valid, 0);
    do_read(5'd5, 32'hA5A5_0005, 0);

    // Random traffic against golden memory
    for (int n = 0; n < 300; n++) begin
      logic [4:0] ra;
      ra = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) do_write(ra, $urandom);
      else do_read(ra, gm[ra], int'($urandom_range(0, 3)));
    end

    // Clear test
    for (int a = 0; a < 32; a++) do_write(5'(a), 32'hFFFFFFFF);
    clear     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 5'd7;
`ifdef RAM_MASTER_CLEAR_EN
    for (int i = 0; i < 32; i++) begin
      step();
      clear     = 1'b0;
      req_valid = 1'b0;
      check("clr_busy", busy, 1);
      check("clr_we", ram_we, 1);
      check("clr_addr", ram_address, i);
      check("clr_data", ram_wdata, 0);
    end
    step();
    check("clr_done", {busy, ram_we}, 0);
    check("clr_norsp", rsp_valid, 0);
    for (int a = 0; a < 32; a++) gm[a] = '0;
`else
    do_read(5'd7, 32'hFFFFFFFF, 0);
    clear = 1'b0;
    step();
    check("noclr_busy", busy, 0);
    check("noclr_we", ram_we, 0);
`endif
    for (int a = 0; a < 32; a++) do_read(5'(a), gm[a], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM data width.
REQ-003 SHALL have parameter MEMORY_DEPTH, default 32, number of RAM words; must be at most 2^ADDRESS_WIDTH.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid_i, input, 1, a request is present.
REQ-007 SHALL have port req_ready_o, output, 1, the block can accept a request.
REQ-008 SHALL have port req_we_i, input, 1, 1 = write request, 0 = read request.
REQ-009 SHALL have port req_addr_i, input, ADDRESS_WIDTH, request address.
REQ-010 SHALL have port req_data_i, input, DATA_WIDTH, write data.
REQ-011 SHALL have port rsp_valid_o, output, 1, read data is present.
REQ-012 SHALL have port rsp_ready_i, input, 1, the consumer takes read data.
REQ-013 SHALL have port rsp_data_o, output, DATA_WIDTH, read data.
REQ-014 SHALL have port ram_address_o, output, ADDRESS_WIDTH, to the RAM address_i.
REQ-015 SHALL have port ram_data_o, output, DATA_WIDTH, to the RAM data_i.
REQ-016 SHALL have port ram_we_o, output, 1, to the RAM we_i.
REQ-017 SHALL have port ram_data_i, input, DATA_WIDTH, from the RAM data_o (registered, 1-cycle read latency).
REQ-018 SHALL have port clear_i, input, 1, start a zero-fill of the RAM.
REQ-019 SHALL have port busy_o, output, 1, the state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, RD_ISSUE, RD_CAPTURE, RESP, CLEAR; req_ready_o = (state==IDLE); all ram_* outputs registered.
REQ-021 SHALL, in IDLE with req_valid_i=1 and req_we_i=1, latch addr/data to ram_address_o/ram_data_o, set ram_we_o=1, and go to WRITE.
REQ-022 SHALL, in WRITE, clear ram_we_o at the next edge and return to IDLE; the RAM writes during the WRITE cycle; max write throughput is 1 per 2 cycles.
REQ-023 SHALL, in IDLE with req_valid_i=1 and req_we_i=0, latch the address to ram_address_o with ram_we_o=0 and go to RD_ISSUE; next edge go to RD_CAPTURE; next edge load ram_data_i into rsp_data_o, set rsp_valid_o=1, and go to RESP.
REQ-024 SHALL give read latency: rsp_valid_o rises 2 edges after the acceptance edge.
REQ-025 SHALL, in RESP, hold rsp_valid_o and rsp_data_o stable until rsp_ready_i=1; on that edge clear rsp_valid_o and return to IDLE; no new request is accepted while in RESP.
REQ-026 SHALL keep ram_we_o=0 in every state except WRITE and CLEAR.
REQ-027 SHALL hold rsp_data_o at its last value after the handshake.
REQ-028 SHALL ignore req_valid_i outside IDLE and SHALL NOT drop or duplicate accepted requests.

Reset
REQ-029 SHALL, on rst_i=1 at a clock edge, force state=IDLE, req_ready_o=1 after the edge, rsp_valid_o=0, rsp_data_o=0, ram_we_o=0, ram_address_o=0, ram_data_o=0, busy_o=0.
REQ-030 SHALL, when reset hits mid-operation (any state), abandon the operation with no response; a write abandoned in WRITE may already have been committed by the RAM.

Configuration
REQ-031 SHALL, when macro RAM_MASTER_CLEAR_EN is defined, handle clear_i=1 in IDLE (priority over req_valid_i in the same cycle; that request is not accepted) as follows: enter CLEAR, write 0 to addresses 0..MEMORY_DEPTH-1, one per cycle with ram_we_o=1, then ram_we_o=0 and return to IDLE; this takes MEMORY_DEPTH cycles in CLEAR.
REQ-032 SHALL, without RAM_MASTER_CLEAR_EN, ignore clear_i, never enter CLEAR, and contain no address counter.

Verification
REQ-033 SHALL cover a write: write 0xDEADBEEF to addr 3, then read addr 3 -> rsp_valid_o high 2 edges after read acceptance with rsp_data_o=0xDEADBEEF.
REQ-034 SHALL cover backpressure: read with rsp_ready_i=0 for 5 cycles -> rsp_valid_o/rsp_data_o stable and req_ready_o=0 throughout; IDLE one edge after rsp_ready_i=1.
REQ-035 SHALL cover back-to-back traffic: writes to addr 0..31 with data=addr*3 and req_valid_i held high -> req_ready_o alternates 1/0; read-back of all 32 words matches.
REQ-036 SHALL cover reset in RESP: rst_i pulsed while rsp_valid_o=1 -> rsp_valid_o=0, req_ready_o=1, next read of addr 5 returns the stored value.
REQ-037 SHALL cover clear with RAM_MASTER_CLEAR_EN: fill RAM with 0xFFFFFFFF, assert clear_i together with req_valid_i -> request not accepted, busy_o high 32 cycles, all reads then return 0; without the macro, clear_i has no effect.
